alu_arbiter: RTL

- Shares one combinational ALU (ops ADD/SUB/MUL/AND/OR, 3-bit control, 32-bit operands, zero flag) between two requesters.
- Requesters include the main pipeline and a side unit such as an address/loop engine.
- Round-robin grant, valid/ready request handshake, one-cycle response pulse.
- MUL is held on the ALU for a configurable number of cycles so a multi-cycle multiplier path can settle.

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu_arbiter_rr_grant2.sv | 31 +++
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared constants for the two-requester ALU arbiter.
//   - ALU control codes (ADD/SUB/MUL/AND/OR); codes 101-111 are unassigned
//     and pass through the arbiter unchanged.
//   - FSM state encodings IDLE/EXEC/RESP.
//   - is_mul(): selects the long EXEC hold for the multiplier path.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// rr_grant2: two-way grant selection for the ALU arbiter.
//   valid_i[1:0]  request valid per requester
//   last_grant_i  id of the requester granted most recently
//   grant_o[1:0]  one-hot (or zero) grant
// Default: round robin, the requester that did not win last time wins a tie.
// With ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie and
// last_grant_i is ignored.
module rr_grant2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o    = '0;
    grant_o[0] = valid_i[0];
    grant_o[1] = valid_i[1] && !valid_i[0];
  end
`else
  always_comb begin
    grant_o    = '0;
    grant_o[0] = valid_i[0] && (!valid_i[1] || last_grant_i);
    grant_o[1] = valid_i[1] && (!valid_i[0] || !last_grant_i);
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//   clk_i, rst_i            clock, synchronous active-high reset
//   reqN_valid_i/ready_o    request handshake (ready only in IDLE, one at a time)
//   reqN_op_i/a_i/b_i       ALU control code and operands
//   rspN_valid_o            one-cycle result strobe
//   rspN_data_o/zero_o      result and zero flag, held until next capture
//   alu_data0_o/data1_o     operands to the ALU (zero while idle)
//   alu_ctrl_o              control code to the ALU (zero while idle)
//   alu_data_i/alu_zero_i   result and zero flag from the ALU
// Accepted ops are latched, driven to the ALU for 1 cycle (MUL_CYCLES for
// MUL), captured, and strobed back to the issuing requester the next cycle.
// Config macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins a tie).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  output logic             rsp0_valid_o,
  output logic [WIDTH-1:0] rsp0_data_o,
  output logic             rsp0_zero_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp1_data_o,
  output logic             rsp1_zero_o,
  output logic [WIDTH-1:0] alu_data0_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i
);

  localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_zero_q, rsp1_zero_d;

  logic [1:0]       grant;

  rr_grant2 u_grant (
    .valid_i      ({req1_valid_i, req0_valid_i}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign req0_ready_o = (state_q == ST_IDLE) && !rst_i && grant[0];
  assign req1_ready_o = (state_q == ST_IDLE) && !rst_i && grant[1];

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign rsp0_zero_o  = rsp0_zero_q;
  assign rsp1_zero_o  = rsp1_zero_q;

  always_comb begin
    alu_data0_o = '0;
    alu_data1_o = '0;
    alu_ctrl_o  = '0;
    if (state_q == ST_EXEC) begin
      alu_data0_o = a_q;
      alu_data1_o = b_q;
      alu_ctrl_o  = op_q;
    end
  end

  // The response strobe is a registered pulse set on the capture cycle, so
  // it is high exactly for the single RESP cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_zero_d  = rsp1_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (req0_ready_o || req1_ready_o) begin
          id_d         = req1_ready_o;
          op_d         = req1_ready_o ? req1_op_i : req0_op_i;
          a_d          = req1_ready_o ? req1_a_i  : req0_a_i;
          b_d          = req1_ready_o ? req1_b_i  : req0_b_i;
          cnt_d        = is_mul(op_d) ? CW'(MUL_CYCLES) : CW'(1);
          last_grant_d = req1_ready_o;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (id_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_data_i;
            rsp1_zero_d  = alu_zero_i;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_data_i;
            rsp0_zero_d  = alu_zero_i;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

endmodule
